// File: rtl/uart_msg_pkg.sv
// uart_msg_pkg: shared state type, message text, trigger decode and table-slicing helpers
package uart_msg_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    localparam logic [7:0] ABORT_CHAR_DEF = 8'h1B;

    localparam logic [63:0]  TXT_H = "Hi there";
    localparam logic [63:0]  TXT_W = "Welcome!";
    localparam logic [111:0] TXT_S = "Status: all ok";
    localparam logic [159:0] TXT_V = "Version 1.2.3 ready.";

    // Text is stored MSB-first in the packed literals; gaps between messages read as zero
    function automatic logic [7:0] rom_byte(input int a);
        if (a < 8) return TXT_H[8*(7-a) +: 8];
        if (a < 16) return TXT_W[8*(15-a) +: 8];
        if (a < 30) return TXT_S[8*(29-a) +: 8];
        if (a >= 32 && a < 52) return TXT_V[8*(51-a) +: 8];
        return 8'h00;
    endfunction

    // Returns {hit, idx}; scanning downward lets the lowest matching index win
    function automatic logic [4:0] trig_match(input logic [7:0] b, input logic [127:0] trig, input int n);
        trig_match = '0;
        for (int i = n - 1; i >= 0; i--)
            if (trig[8*i +: 8] == b) trig_match = {1'b1, 4'(i)};
    endfunction

    function automatic logic [15:0] field(input logic [255:0] v, input int w, input int i);
        return 16'((v >> (w * i)) & ~({256{1'b1}} << w));
    endfunction

endpackage

// File: rtl/msg_char_rom.sv
// msg_char_rom: synchronous character ROM holding the message text, one cycle read latency
module msg_char_rom import uart_msg_pkg::*; #(
    parameter int ROM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(ROM_DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    always_ff @(posedge clk)
        data <= (int'(addr) < ROM_DEPTH) ? rom_byte(int'(addr)) : 8'h00;

endmodule

// File: rtl/uart_msg_dispatcher.sv
// uart_msg_dispatcher: streams a ROM message to the UART TX for each trigger byte received
module uart_msg_dispatcher import uart_msg_pkg::*; #(
    parameter int                         NUM_MSGS   = 4,
    parameter int                         ROM_DEPTH  = 64,
    parameter int                         ADDR_W     = $clog2(ROM_DEPTH),
    parameter int                         LEN_W      = 6,
    parameter logic [NUM_MSGS*8-1:0]      TRIGGERS   = {"v", "s", "w", "h"},
    parameter logic [NUM_MSGS*ADDR_W-1:0] MSG_START  = {6'd32, 6'd16, 6'd8, 6'd0},
    parameter logic [NUM_MSGS*LEN_W-1:0]  MSG_LEN    = {6'd20, 6'd14, 6'd8, 6'd8},
    parameter logic [7:0]                 ABORT_CHAR = ABORT_CHAR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       busy,
    output logic [3:0] active_id,
    output logic       msg_done,
    output logic       aborted,
    output logic       err_unknown
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [LEN_W-1:0]  rem, rem_n;
    logic [3:0]        id_n, pend_id, pend_id_n, ld_id;
    logic              pend_v, pend_v_n, abrt, abrt_n, ld;
    logic [4:0]        m;
    logic              rx_abort, rx_trig, strobe;

    msg_char_rom #(.ROM_DEPTH(ROM_DEPTH), .ADDR_W(ADDR_W)) u_rom (.clk(clk), .addr(addr), .data(tx_data));

    assign m           = trig_match(rx_data, 128'(TRIGGERS), NUM_MSGS);
    assign rx_abort    = new_rx_data && rx_data == ABORT_CHAR;
    assign rx_trig     = new_rx_data && !rx_abort && m[4];
    assign strobe      = state == SEND && !tx_busy;
    assign new_tx_data = strobe;
    assign msg_done    = state == DONE;
    assign aborted     = msg_done && abrt;
    assign busy        = state != IDLE || pend_v;

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        rem_n     = rem;
        id_n      = active_id;
        pend_v_n  = pend_v;
        pend_id_n = pend_id;
        abrt_n    = abrt;
        ld        = 1'b0;
        ld_id     = m[3:0];
        if (strobe) begin
            addr_n  = addr + ADDR_W'(1);
            rem_n   = rem - LEN_W'(1);
            state_n = rem == LEN_W'(1) ? DONE : FETCH;
        end
        if (state == FETCH) state_n = SEND;
        case (state)
            IDLE: ld = rx_trig;
            FETCH, SEND: begin
                if (rx_abort) begin
                    state_n  = DONE;
                    abrt_n   = 1'b1;
                    pend_v_n = 1'b0;
                end else if (rx_trig) begin
                    pend_v_n  = 1'b1;
                    pend_id_n = m[3:0];
                end
            end
            DONE: begin
                state_n = IDLE;
                if (rx_abort) pend_v_n = 1'b0;
                else if (pend_v) begin
                    ld        = 1'b1;
                    ld_id     = pend_id;
                    pend_v_n  = rx_trig;
                    pend_id_n = m[3:0];
                end else ld = rx_trig;
            end
        endcase
        if (ld) begin
            id_n    = ld_id;
            addr_n  = ADDR_W'(field(256'(MSG_START), ADDR_W, int'(ld_id)));
            rem_n   = LEN_W'(field(256'(MSG_LEN), LEN_W, int'(ld_id)));
            abrt_n  = 1'b0;
            state_n = rem_n == '0 ? DONE : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            active_id   <= '0;
            pend_v      <= 1'b0;
            pend_id     <= '0;
            abrt        <= 1'b0;
            err_unknown <= 1'b0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            rem         <= rem_n;
            active_id   <= id_n;
            pend_v      <= pend_v_n;
            pend_id     <= pend_id_n;
            abrt        <= abrt_n;
            err_unknown <= new_rx_data && !rx_abort && !m[4];
        end
    end

endmodule

// File: tb/tb_uart_msg_dispatcher.sv
// tb_uart_msg_dispatcher: directed self-checking bench for the UART message dispatcher
module tb_uart_msg_dispatcher;

    logic       clk = 1'b0, rst = 1'b1, new_rx_data = 1'b0, busy_mode = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy;
    logic [7:0] tx_data0, tx_data1;
    logic       ntx0, ntx1, busy0, busy1, done0, done1, ab0, ab1, err0, err1;
    logic [3:0] id0, id1;
    int         bcnt = 0;

    always #5 clk = ~clk;

    // Simple TX model: busy for 10 cycles after each accepted strobe when enabled
    always @(posedge clk) bcnt <= (busy_mode && ntx0) ? 10 : (bcnt > 0 ? bcnt - 1 : 0);
    assign tx_busy = busy_mode && bcnt != 0;

    uart_msg_dispatcher d0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data), .tx_busy(tx_busy),
        .tx_data(tx_data0), .new_tx_data(ntx0), .busy(busy0), .active_id(id0),
        .msg_done(done0), .aborted(ab0), .err_unknown(err0)
    );

    uart_msg_dispatcher #(.MSG_LEN({6'd20, 6'd14, 6'd8, 6'd0})) d1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data), .tx_busy(tx_busy),
        .tx_data(tx_data1), .new_tx_data(ntx1), .busy(busy1), .active_id(id1),
        .msg_done(done1), .aborted(ab1), .err_unknown(err1)
    );

    logic [7:0] q_data[$];
    int         q_cyc[$];
    int         cyc = 0, err_cnt = 0, done1_cnt = 0, ntx1_cnt = 0, viol = 0;

    always @(negedge clk) begin
        cyc++;
        if (ntx0) begin
            q_data.push_back(tx_data0);
            q_cyc.push_back(cyc);
        end
        if (ntx0 && tx_busy) viol++;
        if (err0) err_cnt++;
        if (done1) done1_cnt++;
        if (ntx1) ntx1_cnt++;
    end

    logic [7:0] rom [64];
    int         tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!done0 && n < max);
        chk({tag, "_seen"}, 32'(done0), 1);
    endtask

    task automatic wait_size(input string tag, input int sz, input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (q_data.size() < sz && n < max);
        chk({tag, "_reached"}, q_data.size(), sz);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_cyc.delete();
    endtask

    initial begin
        string th, tw, ts, tv;
        int e0, d1n, s1;
        th = "Hi there";
        tw = "Welcome!";
        ts = "Status: all ok";
        tv = "Version 1.2.3 ready.";
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        for (int i = 0; i < 8; i++) rom[i] = th[i];
        for (int i = 0; i < 8; i++) rom[8 + i] = tw[i];
        for (int i = 0; i < 14; i++) rom[16 + i] = ts[i];
        for (int i = 0; i < 20; i++) rom[32 + i] = tv[i];

        // Reset state
        repeat (3) @(posedge clk);
        tick();
        chk("rst_new_tx", 32'(ntx0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_aborted", 32'(ab0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_id", 32'(id0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "h" with tx_busy low: 8 strobes, 2 cycles apart
        clear_q();
        send_rx("h");
        wait_done("h", 100);
        chk("h_aborted", 32'(ab0), 0);
        chk("h_busy_at_done", 32'(busy0), 1);
        chk("h_id", 32'(id0), 0);
        tick();
        chk("h_busy_after", 32'(busy0), 0);
        chk("h_count", q_data.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("h_byte%0d", i), 32'(q_data[i]), 32'(rom[i]));
        for (int i = 0; i < 7; i++) chk($sformatf("h_gap%0d", i), q_cyc[i + 1] - q_cyc[i], 2);

        // "w" with a slow transmitter
        clear_q();
        busy_mode = 1'b1;
        send_rx("w");
        wait_done("w", 300);
        busy_mode = 1'b0;
        chk("w_aborted", 32'(ab0), 0);
        chk("w_id", 32'(id0), 1);
        chk("w_count", q_data.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("w_byte%0d", i), 32'(q_data[i]), 32'(rom[8 + i]));
        chk("w_gap", q_cyc[1] - q_cyc[0], 11);
        chk("w_no_strobe_while_busy", viol, 0);
        tick();

        // "s" then "h","v" mid-message: last pending wins
        clear_q();
        e0 = err_cnt;
        send_rx("s");
        wait_size("s_two", 2, 50);
        send_rx("h");
        send_rx("v");
        wait_done("s_first", 300);
        chk("s_first_id", 32'(id0), 2);
        chk("s_first_aborted", 32'(ab0), 0);
        chk("s_first_count", q_data.size(), 14);
        chk("s_busy_pending", 32'(busy0), 1);
        wait_done("s_second", 300);
        chk("s_second_id", 32'(id0), 3);
        chk("s_second_count", q_data.size(), 34);
        for (int i = 0; i < 14; i++) chk($sformatf("s_byte%0d", i), 32'(q_data[i]), 32'(rom[16 + i]));
        for (int i = 0; i < 20; i++) chk($sformatf("v_byte%0d", i), 32'(q_data[14 + i]), 32'(rom[32 + i]));
        chk("s_no_err", err_cnt, e0);
        tick();
        chk("s_idle_busy", 32'(busy0), 0);

        // Abort during FETCH after the 5th strobe, with a pending trigger
        clear_q();
        send_rx("s");
        wait_size("ab_three", 3, 50);
        send_rx("h");
        wait_size("ab_five", 5, 50);
        send_rx(8'h1B);
        wait_done("ab", 50);
        chk("ab_aborted", 32'(ab0), 1);
        chk("ab_id", 32'(id0), 2);
        tick();
        chk("ab_busy_after", 32'(busy0), 0);
        repeat (20) tick();
        chk("ab_count", q_data.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("ab_byte%0d", i), 32'(q_data[i]), 32'(rom[16 + i]));

        // Unknown byte, abort in IDLE, zero-length message
        clear_q();
        e0 = err_cnt;
        send_rx("x");
        tick();
        chk("x_err_pulse", err_cnt, e0 + 1);
        chk("x_busy", 32'(busy0), 0);
        send_rx(8'h1B);
        repeat (3) tick();
        chk("esc_idle_no_err", err_cnt, e0 + 1);
        chk("esc_idle_busy", 32'(busy0), 0);
        chk("x_no_strobe", q_data.size(), 0);
        d1n = done1_cnt;
        s1 = ntx1_cnt;
        send_rx("h");
        wait_done("zl_d0", 100);
        chk("zl_done", done1_cnt, d1n + 1);
        chk("zl_no_strobe", ntx1_cnt, s1);
        tick();

        // Reset mid-message drops the message and the pending slot
        clear_q();
        send_rx("v");
        wait_size("rst_two", 2, 50);
        send_rx("w");
        wait_size("rst_four", 4, 50);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("rstmid_new_tx", 32'(ntx0), 0);
        chk("rstmid_busy", 32'(busy0), 0);
        chk("rstmid_id", 32'(id0), 0);
        repeat (10) tick();
        chk("rstmid_count", q_data.size(), 4);
        chk("rstmid_busy_later", 32'(busy0), 0);

        // Fresh "h" after reset
        clear_q();
        send_rx("h");
        wait_done("h2", 100);
        chk("h2_count", q_data.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("h2_byte%0d", i), 32'(q_data[i]), 32'(rom[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_msg_dispatcher.md
Name: uart_msg_dispatcher

Overview:
- Parametrised UART message server: each of NUM_MSGS trigger bytes received on the RX stream selects one message stored in a character ROM.
- The selected message is streamed byte-by-byte to the UART transmitter using the new_tx_data/tx_busy handshake.
- Adds over the previous printer: a configurable message table, a one-deep pending-command slot, abort-on-character, and status/error outputs.
- Sits between the UART RX/TX cores at the top level.

Parameters:
- NUM_MSGS, 4, number of selectable messages (1..16)
- ROM_DEPTH, 64, character ROM entries
- ADDR_W, $clog2(ROM_DEPTH), ROM address width
- LEN_W, 6, message length width; max length 2^LEN_W-1
- TRIGGERS, {"h","w","s","v"}, packed NUM_MSGS x 8 trigger bytes; index 0 is LSB byte
- MSG_START, {0,8,16,32}, packed NUM_MSGS x ADDR_W start addresses
- MSG_LEN, {8,8,14,20}, packed NUM_MSGS x LEN_W lengths; 0 is legal
- ABORT_CHAR, 8'h1B, RX byte that aborts the active message

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- new_rx_data  in  1  one-cycle strobe; rx_data valid
- tx_busy  in  1  UART TX busy
- tx_data  out  8  byte to transmit (ROM output)
- new_tx_data  out  1  one-cycle transmit strobe
- busy  out  1  message in progress or pending
- active_id  out  4  index of the current or last message
- msg_done  out  1  one-cycle pulse when a message completes or aborts
- aborted  out  1  qualifies msg_done: 1 = ended by abort
- err_unknown  out  1  one-cycle pulse on an unmatched RX byte

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, pending cleared, addr=0, remaining count=0, active_id=0. new_tx_data, msg_done, aborted, err_unknown and busy all 0. tx_data is the ROM output and is not reset.
- Decode: on new_rx_data, compare against all TRIGGERS; the lowest matching index wins.
  - ABORT_CHAR has priority over trigger matching.
  - A byte matching neither pulses err_unknown the next cycle. The byte is otherwise ignored.
- IDLE: on a match, latch id, addr=MSG_START[id], rem=MSG_LEN[id]. Go to FETCH, or go to DONE if rem=0.
- FETCH: one cycle for the synchronous ROM read (1-cycle latency). This cycle also covers the 1-cycle delay before tx_busy rises after a strobe. Go to SEND.
- SEND: wait while tx_busy=1. When tx_busy=0:
  - new_tx_data=1 for exactly one cycle, with tx_data = ROM[addr].
  - addr+1 (wraps modulo ROM_DEPTH); rem-1.
  - If rem was 1, go to DONE; else go to FETCH.
- Strobe spacing: consecutive strobes are never fewer than 2 cycles apart.
- DONE: pulse msg_done for one cycle, with aborted set if the message ended by abort.
  - If pending is valid, load it (as in IDLE) and clear pending.
  - Otherwise go to IDLE.
- Trigger during FETCH/SEND/DONE: stored in the single pending slot. A later trigger overwrites it (last wins). No error is raised.
- ABORT_CHAR:
  - In IDLE: ignored (no error).
  - In FETCH: go to DONE with aborted=1; the character in flight is never strobed.
  - In SEND with tx_busy=0: the strobe in that same cycle still occurs, then the block goes to DONE with aborted=1.
  - In SEND with tx_busy=1: go to DONE with aborted=1 without strobing.
  - Abort also clears pending.
- busy = (state≠IDLE) | pending_valid.
- active_id updates when a message is loaded.
- rst mid-message: the next cycle is IDLE with no strobe, and pending is lost.
- The combinational block defaults every next-state value, so no latches are inferred.

Decomposition:
- Package uart_msg_pkg holds:
  - state enum IDLE/FETCH/SEND/DONE
  - ABORT_CHAR default
  - function trig_match(byte, TRIGGERS) returning {hit, idx}
  - helpers to slice the packed MSG_START/MSG_LEN entries
- Sub-module msg_char_rom (clk, addr, data): synchronous ROM, ROM_DEPTH x 8, initialised from the message text constants.

Test Plan:
- Send "h" with tx_busy held low -> 8 strobes carrying ROM[0..7], spaced exactly 2 cycles apart; then msg_done=1, aborted=0; busy falls the next cycle.
- Send "w" with tx_busy high for 10 cycles after each strobe -> ROM[8..15] delivered in order; no strobe while tx_busy=1.
- Send "s", then during the 3rd character send "h" followed by "v" -> all 14 bytes of "s", then message v (20 bytes from addr 32); h is dropped; two msg_done pulses.
- Send "s", then 0x1B after the 5th strobe -> exactly 5 or 6 strobes per the SEND/FETCH abort rule; msg_done=1 with aborted=1; IDLE; pending cleared.
- Send "x" in IDLE -> err_unknown pulse, no strobe, busy=0. Configure MSG_LEN[0]=0 and send "h" -> msg_done with no strobe.
- Assert rst during the 4th character of "v" -> new_tx_data=0 and busy=0 from the next cycle; a fresh "h" afterwards prints normally.
